// File: rtl/lcd_responder.sv
// HD44780-style LCD bus responder: DDRAM, address counter, busy flag, debug port. Optional LCD_RESP_INIT_CHECK_EN.
// Ops take effect on the cycle after E falls; BF is the only backpressure, and writes issued while busy are dropped and flagged in ERR.
module lcd_responder #(
   parameter int BUSY_CYC = 40,
   parameter int CLR_CYC  = 1600
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic [7:0] LCD_DB_IN,
   output logic [7:0] LCD_DB_OUT,
   output logic       LCD_DB_OE,
   output logic       BF,
   input  logic [6:0] DBG_ADDR,
   output logic [7:0] DBG_DATA,
   output logic [5:0] DISP_CTRL,
   output logic       ERR
);

   localparam int MAXC = (CLR_CYC > BUSY_CYC) ? CLR_CYC : BUSY_CYC;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {IDLE, CLEAR, BUSY_WAIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0]    ac_q, ac_d;
   logic [6:0]    idx_q, idx_d;
   logic          id_q, id_d;
   logic [5:0]    ctrl_q, ctrl_d;
   logic          err_q, err_d;
   logic          e_q;

   logic [7:0]    mem [128];
   logic          mem_we;
   logic [6:0]    mem_wa;
   logic [7:0]    mem_wd;

   logic          busy, fall, wr, rd_data, uninit, reject;
   logic [6:0]    ac_step;

`ifdef LCD_RESP_INIT_CHECK_EN
   logic [1:0]    init_q, init_d;
   logic          fs_ok;
   assign uninit = (init_q != 2'd3);
   assign fs_ok  = ~LCD_RS & (LCD_DB_IN[7:4] == 4'h3);
   assign reject = busy | (uninit & ~fs_ok);
`else
   assign uninit = 1'b0;
   assign reject = busy;
`endif

   assign busy      = (cnt_q != '0);
   assign fall      = e_q & ~LCD_E;
   assign wr        = fall & ~LCD_RW;
   assign rd_data   = fall & LCD_RW & LCD_RS;
   assign ac_step   = id_q ? ac_q + 7'd1 : ac_q - 7'd1;

   assign BF         = busy | uninit;
   assign LCD_DB_OE  = LCD_E & LCD_RW;
   assign LCD_DB_OUT = LCD_RS ? mem[ac_q] : {BF, ac_q};
   assign DBG_DATA   = mem[DBG_ADDR];
   assign DISP_CTRL  = ctrl_q;
   assign ERR        = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = busy ? cnt_q - CW'(1) : cnt_q;
      ac_d    = ac_q;
      idx_d   = idx_q;
      id_d    = id_q;
      ctrl_d  = ctrl_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      mem_wa  = ac_q;
      mem_wd  = LCD_DB_IN;
`ifdef LCD_RESP_INIT_CHECK_EN
      init_d  = init_q;
`endif

      case (state_q)
         CLEAR: begin
            mem_we = 1'b1;
            mem_wa = idx_q;
            mem_wd = 8'h20;
            idx_d  = idx_q + 7'd1;
            if (idx_q == 7'h7F)
               state_d = (cnt_q <= CW'(1)) ? IDLE : BUSY_WAIT;
         end
         BUSY_WAIT: if (cnt_q <= CW'(1)) state_d = IDLE;
         default: ;
      endcase

      if (wr) begin
         if (reject) begin
            err_d = 1'b1;
         end else if (LCD_RS) begin
            mem_we  = 1'b1;
            ac_d    = ac_step;
            cnt_d   = CW'(BUSY_CYC);
            state_d = BUSY_WAIT;
         end else begin
            // Any accepted instruction except no-op/clear/home uses the short busy time
            cnt_d   = CW'(BUSY_CYC);
            state_d = BUSY_WAIT;
            casez (LCD_DB_IN)
               8'b1???????: ac_d = LCD_DB_IN[6:0];
               8'b01??????: ;
               8'b001?????: begin
                  ctrl_d[5:3] = LCD_DB_IN[4:2];
`ifdef LCD_RESP_INIT_CHECK_EN
                  if (uninit) init_d = init_q + 2'd1;
`endif
               end
               8'b0001????: if (!LCD_DB_IN[3]) ac_d = LCD_DB_IN[2] ? ac_q + 7'd1 : ac_q - 7'd1;
               8'b00001???: ctrl_d[2:0] = LCD_DB_IN[2:0];
               8'b000001??: id_d = LCD_DB_IN[1];
               8'b0000001?: begin
                  ac_d  = 7'd0;
                  cnt_d = CW'(CLR_CYC);
               end
               8'b00000001: begin
                  ac_d    = 7'd0;
                  id_d    = 1'b1;
                  idx_d   = 7'd0;
                  cnt_d   = CW'(CLR_CYC);
                  state_d = CLEAR;
               end
               default: begin
                  cnt_d   = cnt_q;
                  state_d = state_q;
               end
            endcase
         end
      end else if (rd_data) begin
         ac_d = ac_step;
      end
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ac_q    <= 7'd0;
         idx_q   <= 7'd0;
         id_q    <= 1'b1;
         ctrl_q  <= 6'd0;
         err_q   <= 1'b0;
         e_q     <= 1'b0;
`ifdef LCD_RESP_INIT_CHECK_EN
         init_q  <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ac_q    <= ac_d;
         idx_q   <= idx_d;
         id_q    <= id_d;
         ctrl_q  <= ctrl_d;
         err_q   <= err_d;
         e_q     <= LCD_E;
`ifdef LCD_RESP_INIT_CHECK_EN
         init_q  <= init_d;
`endif
      end
   end

   // DDRAM is deliberately not reset so an aborted clear leaves partial contents
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: table of bus ops with expected DDRAM/AC/control, plus clear, busy, read and reset corner cases.
module tb_lcd_responder;

   localparam int BUSY = 40;
   localparam int CLR  = 1600;

`ifdef LCD_RESP_INIT_CHECK_EN
   localparam logic BF_RST = 1'b1;
`else
   localparam logic BF_RST = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       e = 1'b0, rs = 1'b0, rw = 1'b0;
   logic [7:0] db = 8'h00;
   logic [7:0] dbo;
   logic       oe, bf, err;
   logic [6:0] dbg_addr = 7'd0;
   logic [7:0] dbg_data;
   logic [5:0] ctrl;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic       rs;
      logic [7:0] db;
      logic [6:0] addr;
      logic [7:0] exp_mem;
      logic [6:0] exp_ac;
      logic [5:0] exp_ctrl;
   } vec_t;

   vec_t vt [20];

   lcd_responder #(.BUSY_CYC(BUSY), .CLR_CYC(CLR)) dut (
      .clk(clk), .RST(rst_n), .LCD_E(e), .LCD_RS(rs), .LCD_RW(rw),
      .LCD_DB_IN(db), .LCD_DB_OUT(dbo), .LCD_DB_OE(oe), .BF(bf),
      .DBG_ADDR(dbg_addr), .DBG_DATA(dbg_data), .DISP_CTRL(ctrl), .ERR(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic r, input logic [7:0] d);
      @(negedge clk);
      rs = r; rw = 1'b0; db = d; e = 1'b1;
      @(negedge clk);
      e = 1'b0;
      @(negedge clk);
   endtask

   task automatic bus_read(input logic r, output logic [7:0] v, output logic drv);
      @(negedge clk);
      rs = r; rw = 1'b1; e = 1'b1;
      #1;
      v = dbo;
      drv = oe;
      @(negedge clk);
      e = 1'b0;
      @(negedge clk);
      rw = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_idle(input int limit, input string name);
      int n = 0;
      while (bf === 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk(name, {15'd0, bf}, 16'd0);
   endtask

   task automatic peek(input logic [6:0] a, input logic [7:0] exp, input string name);
      dbg_addr = a;
      #1;
      chk(name, {8'd0, dbg_data}, {8'd0, exp});
   endtask

   initial begin
      logic [7:0] v;
      logic       drv;
      int         n;

      vt[0]  = '{1'b0, 8'h06, 7'h00, 8'h20, 7'h00, 6'h3C};
      vt[1]  = '{1'b1, 8'h43, 7'h00, 8'h43, 7'h01, 6'h3C};
      vt[2]  = '{1'b1, 8'h41, 7'h01, 8'h41, 7'h02, 6'h3C};
      vt[3]  = '{1'b1, 8'h4C, 7'h02, 8'h4C, 7'h03, 6'h3C};
      vt[4]  = '{1'b0, 8'h04, 7'h02, 8'h4C, 7'h03, 6'h3C};
      vt[5]  = '{1'b0, 8'h80, 7'h00, 8'h43, 7'h00, 6'h3C};
      vt[6]  = '{1'b1, 8'h55, 7'h00, 8'h55, 7'h7F, 6'h3C};
      vt[7]  = '{1'b0, 8'hFF, 7'h7F, 8'h20, 7'h7F, 6'h3C};
      vt[8]  = '{1'b0, 8'h06, 7'h7F, 8'h20, 7'h7F, 6'h3C};
      vt[9]  = '{1'b1, 8'h31, 7'h7F, 8'h31, 7'h00, 6'h3C};
      vt[10] = '{1'b0, 8'h38, 7'h00, 8'h55, 7'h00, 6'h34};
      vt[11] = '{1'b0, 8'h0F, 7'h00, 8'h55, 7'h00, 6'h37};
      vt[12] = '{1'b0, 8'h14, 7'h01, 8'h41, 7'h01, 6'h37};
      vt[13] = '{1'b0, 8'h10, 7'h01, 8'h41, 7'h00, 6'h37};
      vt[14] = '{1'b0, 8'h10, 7'h7F, 8'h31, 7'h7F, 6'h37};
      vt[15] = '{1'b0, 8'h18, 7'h7F, 8'h31, 7'h7F, 6'h37};
      vt[16] = '{1'b0, 8'h0C, 7'h7F, 8'h31, 7'h7F, 6'h34};
      vt[17] = '{1'b0, 8'h02, 7'h00, 8'h55, 7'h00, 6'h34};
      vt[18] = '{1'b0, 8'h40, 7'h00, 8'h55, 7'h00, 6'h34};
      vt[19] = '{1'b0, 8'h00, 7'h02, 8'h4C, 7'h00, 6'h34};

      // Reset state
      wait_cyc(3);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_bf",   {15'd0, bf},   {15'd0, BF_RST});
      chk("rst_err",  {15'd0, err},  16'd0);
      chk("rst_ctrl", {10'd0, ctrl}, 16'd0);
      chk("rst_oe",   {15'd0, oe},   16'd0);
      bus_read(1'b0, v, drv);
      chk("rst_ird",  {8'd0, v},     {8'd0, BF_RST, 7'h00});
      chk("rd_oe",    {15'd0, drv},  16'd1);

`ifdef LCD_RESP_INIT_CHECK_EN
      bus_write(1'b0, 8'h0C);
      wait_cyc(BUSY + 4);
      chk("uninit_err",  {15'd0, err},  16'd1);
      chk("uninit_ctrl", {10'd0, ctrl}, 16'd0);
`endif

      for (int i = 0; i < 3; i++) begin
         bus_write(1'b0, 8'h3C);
         wait_cyc(BUSY + 4);
      end
      chk("fs_ctrl", {10'd0, ctrl}, 16'h0038);
      bus_write(1'b0, 8'h0C);
      wait_idle(BUSY + 10, "dc_idle");
      chk("dc_ctrl", {10'd0, ctrl}, 16'h003C);
`ifndef LCD_RESP_INIT_CHECK_EN
      chk("init_err", {15'd0, err}, 16'd0);
`endif

      // Clear: BF duration and fill
      bus_write(1'b0, 8'h01);
      n = 0;
      while (bf === 1'b1 && n < CLR + 100) begin
         n++;
         @(negedge clk);
      end
      chk("clr_bf_cycles", 16'(n), 16'(CLR));
      peek(7'h00, 8'h20, "clr_m00");
      peek(7'h3F, 8'h20, "clr_m3f");
      peek(7'h7F, 8'h20, "clr_m7f");
      bus_read(1'b0, v, drv);
      chk("clr_ac", {8'd0, v}, 16'h0000);

      for (int i = 0; i < 20; i++) begin
         bus_write(vt[i].rs, vt[i].db);
         wait_idle(CLR + 100, $sformatf("v%0d_idle", i));
         peek(vt[i].addr, vt[i].exp_mem, $sformatf("v%0d_mem", i));
         bus_read(1'b0, v, drv);
         chk($sformatf("v%0d_ac", i), {8'd0, v}, {8'd0, 1'b0, vt[i].exp_ac});
         chk($sformatf("v%0d_ctrl", i), {10'd0, ctrl}, {10'd0, vt[i].exp_ctrl});
      end

      // Write while busy is dropped and ERR sticks
`ifndef LCD_RESP_INIT_CHECK_EN
      chk("pre_busy_err", {15'd0, err}, 16'd0);
`endif
      bus_write(1'b0, 8'h3C);
      bus_write(1'b1, 8'h99);
      wait_idle(BUSY + 10, "bw_idle");
      peek(7'h00, 8'h55, "bw_mem");
      bus_read(1'b0, v, drv);
      chk("bw_ac",   {8'd0, v},     16'h0000);
      chk("bw_err",  {15'd0, err},  16'd1);
      chk("bw_ctrl", {10'd0, ctrl}, 16'h003C);
      wait_cyc(50);
      chk("bw_err_sticky", {15'd0, err}, 16'd1);

      // Data read returns DDRAM[AC] and advances AC
      bus_read(1'b1, v, drv);
      chk("drd_val", {8'd0, v},    16'h0055);
      chk("drd_oe",  {15'd0, drv}, 16'd1);
      bus_read(1'b0, v, drv);
      chk("drd_ac",  {8'd0, v},    16'h0001);

      // Reset in the middle of a clear
      bus_write(1'b0, 8'h01);
      wait_cyc(10);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      peek(7'h00, 8'h20, "mc_m00");
      peek(7'h01, 8'h20, "mc_m01");
      peek(7'h7F, 8'h31, "mc_m7f");
      chk("mc_bf",   {15'd0, bf},   {15'd0, BF_RST});
      chk("mc_err",  {15'd0, err},  16'd0);
      chk("mc_ctrl", {10'd0, ctrl}, 16'd0);
      bus_read(1'b0, v, drv);
      chk("mc_ird",  {8'd0, v},     {8'd0, BF_RST, 7'h00});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lcd_responder.md
Name: lcd_responder

Overview:
Device-side (HD44780-compatible) responder for the 8-bit LCD bus driven by the team's display driver: accepts E/RS/RW/DB strobes, executes the instruction set against an internal DDRAM and address counter, and answers busy-flag and data reads. Used as a synthesizable display model in simulation and on-board loopback, so driver init, busy polling and character streaming can be checked without a physical panel. A side debug port exposes DDRAM contents.

Parameters:
BUSY_CYC, 40, clk cycles BF stays high after any write except clear/home
CLR_CYC, 1600, clk cycles BF stays high after clear (0x01) or return home (0x02/0x03); must be >= 128

Ports:
clk  input  1  system clock; all bus inputs sampled on its rising edge
RST  input  1  asynchronous active-low reset
LCD_E  input  1  enable strobe from driver
LCD_RS  input  1  register select: 0 instruction, 1 data
LCD_RW  input  1  0 write, 1 read
LCD_DB_IN  input  8  bus value driven by host
LCD_DB_OUT  output  8  read data: {BF,AC} when RS=0, DDRAM[AC] when RS=1
LCD_DB_OE  output  1  responder drives bus; equals LCD_E & LCD_RW
BF  output  1  busy flag, also LCD_DB_OUT[7] on instruction reads
DBG_ADDR  input  7  debug DDRAM read address
DBG_DATA  output  8  DDRAM[DBG_ADDR], combinational
DISP_CTRL  output  6  {DL,N,F,D,C,B}, last function-set and display-control bits
ERR  output  1  sticky protocol error flag

Behaviour:
- Reset (async, RST=0): AC=0, BF=0, I/D=1, DISP_CTRL=6'b0, ERR=0, busy counter=0, e_q=0, FSM=IDLE. DDRAM is not reset (uninitialized until first clear).
- Strobe detection: e_q <= LCD_E each cycle; falling edge = e_q & ~LCD_E. RS, RW, DB_IN captured in that same cycle. E high >= 1 cycle is required; no internal synchronizer (inputs synchronous to clk).
- Write, RS=0 (instruction) decode on DB_IN, priority highest set bit:
  1xxxxxxx set DDRAM addr: AC=DB[6:0].
  01xxxxxx set CGRAM addr: accepted, no effect except busy.
  001xxxxx function set: DL,N,F=DB[4:2].
  0001xxxx cursor/display shift: if DB[3]=0, AC+=1 when DB[2]=1 else AC-=1; if DB[3]=1 no AC change.
  00001xxx display control: D,C,B=DB[2:0].
  000001xx entry mode: I/D=DB[1]; S ignored.
  0000001x return home: AC=0, busy CLR_CYC.
  00000001 clear: AC=0, I/D=1, FSM->CLEAR, busy CLR_CYC.
  00000000 no-op, no busy.
- Write, RS=1: DDRAM[AC]=DB_IN, then AC+=1 (I/D=1) or AC-=1 (I/D=0).
- Read, RS=1: LCD_DB_OUT=DDRAM[AC] while E high; on falling edge AC steps per I/D, no busy.
- Read, RS=0: LCD_DB_OUT={BF,AC} while E high; no state change.
- AC is 7 bits, wraps modulo 128 both directions (0x7F+1=0x00, 0x00-1=0x7F).
- Busy: BF rises the cycle after the falling edge that starts an operation; down-counter loaded with BUSY_CYC or CLR_CYC; BF falls the cycle the counter reaches 0.
- FSM: IDLE -> (clear) CLEAR: writes 0x20 to DDRAM[i], i=0..127, one per cycle -> BUSY_WAIT until counter=0 -> IDLE. Other busy ops: IDLE -> BUSY_WAIT -> IDLE.
- Writes while BF=1: ignored (no DDRAM/AC/register change), ERR set. Reads while busy are legal and return current state.
- Simultaneous DBG_ADDR read and internal write to same address: DBG_DATA shows the old value that cycle.
- Reset mid-clear: aborts fill immediately; partially cleared DDRAM retains contents.

Optional Feature:
LCD_RESP_INIT_CHECK_EN: when defined, responder starts in UNINIT; before three function-set writes (0x3X) have been received, any other write is ignored and sets ERR; busy-flag reads in UNINIT return BF=1. When undefined, all commands are accepted immediately after reset.

Test Plan:
- Reset, write 0x01, poll BF -> BF=1 for exactly CLR_CYC cycles, then DBG_DATA=0x20 at addresses 0x00, 0x3F, 0x7F; AC=0.
- Write 0x06, then data 0x43,0x41,0x4C -> DDRAM[0..2]=0x43,0x41,0x4C, instruction read returns {0,7'h03}.
- Write 0x04, 0x80, data 0x55 -> DDRAM[0x00]=0x55, AC=0x7F (wrap-down).
- Write 0xFF then 0x06 then data 0x31 -> DDRAM[0x7F]=0x31, AC=0x00 (wrap-up).
- Data write issued while BF=1 after 0x3C -> DDRAM unchanged, ERR=1 and remains set until reset.
- With LCD_RESP_INIT_CHECK_EN: 0x0C before any 0x3C -> ERR=1, DISP_CTRL unchanged; after 3x 0x3C, 0x0C -> DISP_CTRL=6'b111100.
